pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline-stage register with a valid/ready handshake on both sides, an optional two-entry skid buffer, flush-to-bubble, and saturating stall/bubble counters. It replaces the fixed per-stage registers between IF/ID/EX/MEM/WB. Each stage boundary instantiates it once, with stage-specific payload and control widths. Payload fields (PC, operands, immediates) go on the data bus. Side-effecting control (reg_write, mem_read, mem_write, branch) goes on the control bus, which is forced to a safe value whenever the entry is not valid.

## Interface
Parameters:
- DATA_W, 32: payload width. Payload is not cleared by flush or bubble.
- CTRL_W, 8: control width. Driven as CTRL_RST whenever the output is not valid.
- CTRL_RST, 0: control value for reset, bubble and flush (CTRL_W bits).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o.
- CNT_W, 16: counter width.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- flush_i, input, 1: invalidate all held entries.
- in_valid_i, input, 1: upstream entry valid.
- in_ready_o, output, 1: stage can accept an entry this cycle.
- in_data_i, input, DATA_W: upstream payload.
- in_ctrl_i, input, CTRL_W: upstream control.
- out_valid_o, output, 1: output entry valid.
- out_ready_i, input, 1: downstream accepts this cycle.
- out_data_o, output, DATA_W: output payload.
- out_ctrl_o, output, CTRL_W: output control; equals CTRL_RST when out_valid_o = 0.
- occupancy_o, output, 2: number of held entries (0..2; 0..1 when SKID = 0).
- stall_cnt_o, output, CNT_W: count of cycles with out_valid_o & !out_ready_i.
- bubble_cnt_o, output, CNT_W: count of cycles with !out_valid_o & out_ready_i.

## Operation
- Handshake terms:
  - Input transfer (acc) = in_valid_i & in_ready_o.
  - Output transfer (pop) = out_valid_o & out_ready_i.
  - Once raised, in_valid_i must hold with stable data and control until acc. The block's out_valid_o obeys the same rule.
- Storage: main entry (m_v, m_data, m_ctrl) drives the outputs directly. The skid entry (s_v, s_data, s_ctrl) exists only when SKID = 1.
- SKID = 1 update rules:
  - in_ready_o = !s_v, taken from a register with no combinational path from out_ready_i.
  - acc, and main empty or popping: new entry goes into main (unless skid is valid, see next rule).
  - Skid valid and popping: skid moves into main and s_v clears. An acc in the same cycle is impossible, because in_ready_o = 0.
  - acc while main is held and not popping: entry goes into skid and s_v sets.
  - pop with no replacement entry: m_v clears.
- SKID = 0:
  - in_ready_o = !m_v | out_ready_i (combinational).
  - acc loads main. A pop without acc clears m_v.
- Flush:
  - m_v and s_v clear at the next edge, and an acc in the flush cycle is discarded.
  - A pop in the flush cycle still counts as completed, because downstream consumed it.
  - Payload registers keep their old contents. Control outputs show CTRL_RST.
- out_ctrl_o = m_v ? m_ctrl : CTRL_RST.
- out_data_o = m_data whenever m_v = 0 (stale payload is allowed).
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at 2^CNT_W-1 with no wrap.
  - Only rst clears them; flush does not.
  - The counters are evaluated on the pre-edge outputs, including in flush cycles.
- occupancy_o = m_v + s_v.
- Reset (rst = 1 at an edge):
  - m_v = s_v = 0.
  - m_data = s_data = 0.
  - m_ctrl = s_ctrl = CTRL_RST.
  - Counters = 0.
  - Resulting outputs: out_valid_o = 0, out_data_o = 0, out_ctrl_o = CTRL_RST, occupancy_o = 0, in_ready_o = 1.
  - While rst is high, all inputs are ignored. Reset takes priority over flush, which takes priority over the handshake.

## Timing
- Latency: 1 cycle. An acc at edge N appears on the outputs after edge N when the block was empty.
- Throughput: 1 entry per cycle with out_ready_i held high, for both SKID values.
- SKID = 1 backpressure:
  - One extra entry is absorbed after out_ready_i falls.
  - in_ready_o falls on the edge after the skid entry fills.
  - in_ready_o rises on the edge after the skid entry drains.
- Full (occupancy 2) with out_ready_i = 1: the next edge gives occupancy 1 and in_ready_o = 1.
- Empty with flush_i and in_valid_i both high: occupancy stays 0.
- Reset asserted with occupancy 2: the next edge gives occupancy 0 and no output transfer is counted after that edge.

## Test plan
- Stream 8 entries (data 0x10..0x17) with out_ready_i = 1 and SKID = 1 → outputs 0x10..0x17 on consecutive cycles, 1-cycle latency, stall_cnt_o = 0.
- Hold out_ready_i = 0 with in_valid_i = 1 carrying 0xA, 0xB, 0xC → 0xA held, 0xB in skid, occupancy_o = 2, in_ready_o = 0. Release out_ready_i → 0xA, 0xB, 0xC emitted in order with no loss or duplication. stall_cnt_o equals the number of held cycles.
- Occupancy 2, assert flush_i for 1 cycle with in_valid_i = 1 → next cycle out_valid_o = 0, out_ctrl_o = CTRL_RST, occupancy_o = 0, and the flushed-cycle input is not emitted.
- Run with CNT_W = 4 and 20 idle cycles with out_ready_i = 1 → bubble_cnt_o saturates at 15.
- SKID = 0 with out_ready_i toggling every cycle → in_ready_o follows !m_v | out_ready_i in the same cycle and every accepted entry emerges exactly once.
- rst pulsed mid-stream at occupancy 2 → all outputs return to their reset values at the next edge, and the stream resumes from the first post-reset acc.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pipe_stage_reg                                                |
// | Elastic valid/ready pipeline register, optional 2-entry skid buffer,   |
// | flush-to-bubble and saturating stall/bubble counters.                  |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module pipe_stage_reg #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0,
    parameter int                SKID     = 1,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic              r_m_v;
    logic [DATA_W-1:0] r_m_data;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic              w_s_v;
    logic              w_acc;
    logic              w_pop;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    assign w_acc = in_valid_i & in_ready_o;
    assign w_pop = r_m_v & out_ready_i;

    generate
        if (SKID != 0) begin : g_skid
            logic              r_s_v;
            logic [DATA_W-1:0] r_s_data;
            logic [CTRL_W-1:0] r_s_ctrl;

            // in_ready comes straight from r_s_v, so it never depends on out_ready_i
            assign in_ready_o = ~r_s_v;
            assign w_s_v      = r_s_v;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_m_v    <= 1'b0;
                    r_m_data <= '0;
                    r_m_ctrl <= CTRL_RST;
                    r_s_v    <= 1'b0;
                    r_s_data <= '0;
                    r_s_ctrl <= CTRL_RST;
                end else if (flush_i) begin
                    r_m_v <= 1'b0;
                    r_s_v <= 1'b0;
                end else if (r_s_v) begin
                    if (w_pop) begin
                        r_m_data <= r_s_data;
                        r_m_ctrl <= r_s_ctrl;
                        r_s_v    <= 1'b0;
                    end
                end else if (w_acc) begin
                    if (!r_m_v || w_pop) begin
                        r_m_v    <= 1'b1;
                        r_m_data <= in_data_i;
                        r_m_ctrl <= in_ctrl_i;
                    end else begin
                        r_s_v    <= 1'b1;
                        r_s_data <= in_data_i;
                        r_s_ctrl <= in_ctrl_i;
                    end
                end else if (w_pop) begin
                    r_m_v <= 1'b0;
                end
            end
        end else begin : g_no_skid
            assign in_ready_o = ~r_m_v | out_ready_i;
            assign w_s_v      = 1'b0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_m_v    <= 1'b0;
                    r_m_data <= '0;
                    r_m_ctrl <= CTRL_RST;
                end else if (flush_i) begin
                    r_m_v <= 1'b0;
                end else if (w_acc) begin
                    r_m_v    <= 1'b1;
                    r_m_data <= in_data_i;
                    r_m_ctrl <= in_ctrl_i;
                end else if (w_pop) begin
                    r_m_v <= 1'b0;
                end
            end
        end
    endgenerate

    // Counters look at the pre-edge outputs, flush cycles included
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_m_v && !out_ready_i && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            if (!r_m_v && out_ready_i && (r_bubble_cnt != c_cnt_max))
                r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
        end
    end

    assign out_valid_o  = r_m_v;
    assign out_data_o   = r_m_data;
    assign out_ctrl_o   = r_m_v ? r_m_ctrl : CTRL_RST;
    assign occupancy_o  = {1'b0, r_m_v} + {1'b0, w_s_v};
    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_pipe_stage_reg                                             |
// | Randomised + directed bench for pipe_stage_reg against a FIFO model.   |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_pipe_stage_reg;

    localparam int         DW   = 16;
    localparam int         CW   = 8;
    localparam logic [7:0] CRST = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int          cur;
    logic        rst, flush, in_valid, out_ready;
    logic [15:0] in_data;
    logic [7:0]  in_ctrl;
    logic [2:0]  rst_v;

    // Only the instance under test leaves reset
    always_comb begin
        rst_v = '1;
        for (int i = 0; i < 3; i++) rst_v[i] = rst || (cur != i);
    end

    logic ir0, ov0, ir1, ov1, ir2, ov2;
    logic [15:0] od0, od1, od2;
    logic [7:0]  oc0, oc1, oc2;
    logic [1:0]  occ0, occ1, occ2;
    logic [15:0] sc0, bc0, sc1, bc1;
    logic [3:0]  sc2, bc2;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .rst(rst_v[0]), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir0),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(ov0), .out_ready_i(out_ready),
        .out_data_o(od0), .out_ctrl_o(oc0), .occupancy_o(occ0), .stall_cnt_o(sc0), .bubble_cnt_o(bc0));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST), .SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst_v[1]), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir1),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(ov1), .out_ready_i(out_ready),
        .out_data_o(od1), .out_ctrl_o(oc1), .occupancy_o(occ1), .stall_cnt_o(sc1), .bubble_cnt_o(bc1));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST), .SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst_v[2]), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir2),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(ov2), .out_ready_i(out_ready),
        .out_data_o(od2), .out_ctrl_o(oc2), .occupancy_o(occ2), .stall_cnt_o(sc2), .bubble_cnt_o(bc2));

    logic        d_ready, d_valid;
    logic [15:0] d_data;
    logic [7:0]  d_ctrl;
    logic [1:0]  d_occ;
    logic [31:0] d_stall, d_bubble;

    always_comb begin
        d_ready = ir0; d_valid = ov0; d_data = od0; d_ctrl = oc0; d_occ = occ0;
        d_stall = {16'd0, sc0}; d_bubble = {16'd0, bc0};
        if (cur == 1) begin
            d_ready = ir1; d_valid = ov1; d_data = od1; d_ctrl = oc1; d_occ = occ1;
            d_stall = {16'd0, sc1}; d_bubble = {16'd0, bc1};
        end else if (cur == 2) begin
            d_ready = ir2; d_valid = ov2; d_data = od2; d_ctrl = oc2; d_occ = occ2;
            d_stall = {28'd0, sc2}; d_bubble = {28'd0, bc2};
        end
    end

    // Reference model: a bounded FIFO of {ctrl,data} plus two counters
    logic [23:0] mq[$];
    int          m_stall, m_bubble, cnt_max;
    bit          skid_mode, last_acc;
    int          n_chk, n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        if (skid_mode) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    task automatic check_outputs();
        logic [23:0] head;
        chk("out_valid", d_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            head = mq[0];
            chk("out_data", d_data, head[15:0]);
            chk("out_ctrl", d_ctrl, head[23:16]);
        end else begin
            chk("out_ctrl_idle", d_ctrl, CRST);
        end
        chk("occupancy", d_occ, mq.size());
        chk("stall_cnt", d_stall, m_stall);
        chk("bubble_cnt", d_bubble, m_bubble);
    endtask

    // One clock: inputs already driven after a negedge
    task automatic step();
        bit acc, pop, er;
        #1;
        er = exp_ready();
        chk("in_ready", d_ready, er);
        acc = in_valid && er && !rst;
        pop = (mq.size() > 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_stall  = 0;
            m_bubble = 0;
            last_acc = 1'b1;
        end else begin
            if (mq.size() > 0 && !out_ready && m_stall < cnt_max) m_stall++;
            if (mq.size() == 0 && out_ready && m_bubble < cnt_max) m_bubble++;
            if (flush) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back({in_ctrl, in_data});
            end
            last_acc = acc;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input bit v, input logic [15:0] d, input bit rdy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = d[7:0] ^ 8'h3C;
        out_ready = rdy;
        flush     = 1'b0;
        step();
    endtask

    task automatic drive_rand(input int pv, input int pr, input int pf);
        if (!(in_valid && !last_acc)) begin
            in_valid = ($urandom_range(99) < pv);
            in_data  = 16'($urandom);
            in_ctrl  = 8'($urandom);
        end
        out_ready = ($urandom_range(99) < pr);
        flush     = ($urandom_range(99) < pf);
    endtask

    task automatic select(input int idx, input bit sk, input int cmax);
        cur       = idx;
        skid_mode = sk;
        cnt_max   = cmax;
        mq.delete();
        m_stall   = 0;
        m_bubble  = 0;
        last_acc  = 1'b1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    logic [15:0] seen[$];
    logic [15:0] want[3];

    initial begin
        n_chk = 0; n_err = 0;
        cur = 0; skid_mode = 1'b1; cnt_max = 65535; last_acc = 1'b1;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        @(posedge clk); @(negedge clk);
        step();
        rst = 1'b0;
        chk("rst_data", d_data, 16'h0);
        chk("rst_ready", d_ready, 1'b1);

        // Streaming with 1-cycle latency
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 16'h10 + 16'(i), 1'b1);
            chk("stream_data", d_data, 16'h10 + 16'(i));
        end
        send(1'b0, 16'h0, 1'b1);
        chk("stream_stall", d_stall, 0);

        // Backpressure fills main then skid
        send(1'b1, 16'h0A, 1'b0);
        send(1'b1, 16'h0B, 1'b0);
        send(1'b1, 16'h0C, 1'b0);
        chk("bp_occ", d_occ, 2);
        chk("bp_ready", d_ready, 1'b0);
        send(1'b1, 16'h0C, 1'b0);
        chk("bp_head", d_data, 16'h0A);
        chk("bp_stall", d_stall, 3);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (d_valid) seen.push_back(d_data);
            step();
            if (last_acc) in_valid = 1'b0;
        end
        want[0] = 16'h0A; want[1] = 16'h0B; want[2] = 16'h0C;
        chk("bp_count", seen.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < seen.size()) chk("bp_order", seen[i], want[i]);

        // Flush while full, with a valid input present
        send(1'b1, 16'h21, 1'b0);
        send(1'b1, 16'h22, 1'b0);
        in_valid = 1'b1; in_data = 16'h23; flush = 1'b1; out_ready = 1'b0;
        step();
        chk("flush_valid", d_valid, 1'b0);
        chk("flush_ctrl", d_ctrl, CRST);
        chk("flush_occ", d_occ, 0);
        send(1'b0, 16'h0, 1'b1);
        send(1'b0, 16'h0, 1'b1);
        chk("flush_no_emit", d_valid, 1'b0);
        // Flush while empty discards the accepted entry
        in_valid = 1'b1; in_data = 16'h24; flush = 1'b1; out_ready = 1'b1;
        step();
        chk("flush_empty_occ", d_occ, 0);

        // Reset mid-stream at occupancy 2
        send(1'b1, 16'h31, 1'b0);
        send(1'b1, 16'h32, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h33; out_ready = 1'b1; flush = 1'b0;
        step();
        rst = 1'b0;
        chk("mrst_occ", d_occ, 0);
        chk("mrst_valid", d_valid, 1'b0);
        chk("mrst_data", d_data, 16'h0);
        chk("mrst_ctrl", d_ctrl, CRST);
        chk("mrst_stall", d_stall, 0);
        send(1'b1, 16'h34, 1'b1);
        chk("mrst_resume", d_data, 16'h34);

        for (int i = 0; i < 300; i++) begin
            drive_rand(60, 60, 3);
            step();
        end

        // Single-entry variant with out_ready toggling
        select(1, 1'b0, 65535);
        for (int i = 0; i < 200; i++) begin
            drive_rand(70, 0, 2);
            out_ready = i[0];
            step();
        end

        // Narrow counters saturate
        select(2, 1'b1, 15);
        for (int i = 0; i < 20; i++) send(1'b0, 16'h0, 1'b1);
        chk("bubble_sat", d_bubble, 15);
        for (int i = 0; i < 100; i++) begin
            drive_rand(80, 25, 1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
